// File: rtl/simulacion_core_if.sv
// Operand, function-select and monitor signals of the two-input function cell.
// The master side drives the operands and observes the results; the slave side is the core.
interface simulacion_core_if #(
    parameter int CNT_W = 8
);
    logic             a;
    logic             b;
    logic [2:0]       func;
    logic             c;
    logic             c_toggle;
    logic [CNT_W-1:0] toggle_count;
    logic [3:0]       combo_seen;

    modport master (
        output a,
        output b,
        output func,
        input  c,
        input  c_toggle,
        input  toggle_count,
        input  combo_seen
    );

    modport slave (
        input  a,
        input  b,
        input  func,
        output c,
        output c_toggle,
        output toggle_count,
        output combo_seen
    );
endinterface

// File: rtl/simulacion_core.sv
// Registered two-input Boolean function unit with activity monitors.
// The result register c is paired with a transition pulse, a saturating count of
// transitions and sticky flags recording which {a,b} pairs have been sampled.
module simulacion_core #(
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    simulacion_core_if.slave bus_io
);

    localparam logic [CNT_W-1:0] CountOne = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CountMax = {CNT_W{1'b1}};

    logic             c_q, c_d;
    logic             c_toggle_q, c_toggle_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       combo_q, combo_d;
    logic [1:0]       ab;

    // Evaluate the selected function and derive the next monitor state from it
    always_comb begin
        ab         = {bus_io.a, bus_io.b};
        c_d        = 1'b0;
        c_toggle_d = 1'b0;
        count_d    = count_q;
        combo_d    = combo_q;

        unique case (bus_io.func)
            3'b000:  c_d = bus_io.a & bus_io.b;
            3'b001:  c_d = bus_io.a | bus_io.b;
            3'b010:  c_d = bus_io.a ^ bus_io.b;
            3'b011:  c_d = ~(bus_io.a & bus_io.b);
            3'b100:  c_d = ~(bus_io.a | bus_io.b);
            3'b101:  c_d = ~(bus_io.a ^ bus_io.b);
            3'b110:  c_d = bus_io.a;
            default: c_d = bus_io.b;
        endcase

        combo_d[ab] = 1'b1;

        if (c_d != c_q) begin
            c_toggle_d = 1'b1;
            if (count_q != CountMax) begin
                count_d = count_q + CountOne;
            end
        end
    end

    // Result and monitor registers; reset clears everything including a pending pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q        <= 1'b0;
            c_toggle_q <= 1'b0;
            count_q    <= '0;
            combo_q    <= 4'b0000;
        end else begin
            c_q        <= c_d;
            c_toggle_q <= c_toggle_d;
            count_q    <= count_d;
            combo_q    <= combo_d;
        end
    end

    assign bus_io.c            = c_q;
    assign bus_io.c_toggle     = c_toggle_q;
    assign bus_io.toggle_count = count_q;
    assign bus_io.combo_seen   = combo_q;

endmodule

// File: tb/tb_simulacion_core.sv
// Directed bench for simulacion_core: one 8-bit-counter instance and one 2-bit-counter
// instance driven with identical stimulus, checked against a truth-table model and
// hand-computed values at the key points.
module tb_simulacion_core;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    simulacion_core_if #(.CNT_W(8)) busBig ();
    simulacion_core_if #(.CNT_W(2)) busSmall ();

    simulacion_core #(.CNT_W(8)) dutBig (
        .clk    (clk),
        .rst    (rst),
        .bus_io (busBig.slave)
    );

    simulacion_core #(.CNT_W(2)) dutSmall (
        .clk    (clk),
        .rst    (rst),
        .bus_io (busSmall.slave)
    );

    int totalChecks = 0;
    int badChecks   = 0;

    // Truth table per function: bit {a,b} holds the result for that operand pair
    logic [3:0] funcTable [8] = '{
        4'b1000,   // AND
        4'b1110,   // OR
        4'b0110,   // XOR
        4'b0111,   // NAND
        4'b0001,   // NOR
        4'b1001,   // XNOR
        4'b1100,   // pass A
        4'b1010    // pass B
    };

    logic       mC;
    logic       mToggle;
    int         mCount8;
    int         mCount2;
    logic [3:0] mCombo;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected) else begin
            badChecks++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs to both instances, then advance the reference model
    task automatic applyStimulus(input logic aIn, input logic bIn, input logic [2:0] fIn, input logic rIn);
        logic newC;
        busBig.a      = aIn;
        busBig.b      = bIn;
        busBig.func   = fIn;
        busSmall.a    = aIn;
        busSmall.b    = bIn;
        busSmall.func = fIn;
        rst           = rIn;
        @(posedge clk);
        #1;
        if (rIn) begin
            mC      = 1'b0;
            mToggle = 1'b0;
            mCount8 = 0;
            mCount2 = 0;
            mCombo  = 4'b0000;
        end else begin
            newC    = funcTable[fIn][{aIn, bIn}];
            mToggle = (newC != mC);
            if (mToggle) begin
                if (mCount8 < 255) mCount8++;
                if (mCount2 < 3) mCount2++;
            end
            mC = newC;
            mCombo[{aIn, bIn}] = 1'b1;
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".c"},          32'(busBig.c),            32'(mC));
        checkOutput({tag, ".tog"},        32'(busBig.c_toggle),     32'(mToggle));
        checkOutput({tag, ".cnt"},        32'(busBig.toggle_count), 32'(mCount8));
        checkOutput({tag, ".combo"},      32'(busBig.combo_seen),   32'(mCombo));
        checkOutput({tag, ".small.c"},    32'(busSmall.c),          32'(mC));
        checkOutput({tag, ".small.cnt"},  32'(busSmall.toggle_count), 32'(mCount2));
    endtask

    initial begin
        logic [1:0] andPairs [5];
        logic       andExpC  [5];
        logic [1:0] pair;

        andPairs = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b11};
        andExpC  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset held two cycles with operands that would otherwise drive c high
        applyStimulus(1'b1, 1'b1, 3'b001, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b001, 1'b1);
        checkOutput("reset.c",     32'(busBig.c),            32'd0);
        checkOutput("reset.tog",   32'(busBig.c_toggle),     32'd0);
        checkOutput("reset.cnt",   32'(busBig.toggle_count), 32'd0);
        checkOutput("reset.combo", 32'(busBig.combo_seen),   32'd0);

        // AND truth table, each pair held five cycles
        for (int s = 0; s < 5; s++) begin
            for (int k = 0; k < 5; k++) begin
                applyStimulus(andPairs[s][1], andPairs[s][0], 3'b000, 1'b0);
                checkModel($sformatf("and%0d_%0d", s, k));
                checkOutput($sformatf("and%0d_%0d.hand_c", s, k), 32'(busBig.c), 32'(andExpC[s]));
                checkOutput($sformatf("and%0d_%0d.hand_tog", s, k), 32'(busBig.c_toggle),
                            (s == 3 && k == 0) ? 32'd1 : 32'd0);
            end
        end
        checkOutput("and.hand_cnt",   32'(busBig.toggle_count), 32'd1);
        checkOutput("and.hand_combo", 32'(busBig.combo_seen),   32'hF);

        // Glitch between edges must not matter
        busBig.a = 1'b0;
        busSmall.a = 1'b0;
        #2;
        busBig.a = 1'b1;
        busSmall.a = 1'b1;
        applyStimulus(1'b1, 1'b1, 3'b000, 1'b0);
        checkOutput("glitch.c",   32'(busBig.c),        32'd1);
        checkOutput("glitch.tog", 32'(busBig.c_toggle), 32'd0);

        // Every function over every operand pair
        for (int f = 0; f < 8; f++) begin
            for (int p = 0; p < 4; p++) begin
                pair = 2'(p);
                applyStimulus(pair[1], pair[0], 3'(f), 1'b0);
                checkModel($sformatf("func%0d_ab%0d", f, p));
            end
        end

        // Function change alone toggles c and is counted
        applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
        checkOutput("fchg.c0",   32'(busBig.c),            32'd0);
        checkOutput("fchg.cnt0", 32'(busBig.toggle_count), 32'd0);
        applyStimulus(1'b1, 1'b0, 3'b001, 1'b0);
        checkOutput("fchg.c1",   32'(busBig.c),            32'd1);
        checkOutput("fchg.tog1", 32'(busBig.c_toggle),     32'd1);
        checkOutput("fchg.cnt1", 32'(busBig.toggle_count), 32'd1);
        checkModel("fchg");

        // Saturation of the 2-bit counter with XOR and a toggling every cycle
        applyStimulus(1'b0, 1'b0, 3'b010, 1'b1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus((k % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 3'b010, 1'b0);
            checkOutput($sformatf("sat%0d.small_cnt", k), 32'(busSmall.toggle_count),
                        (k < 3) ? 32'(k + 1) : 32'd3);
            checkOutput($sformatf("sat%0d.small_tog", k), 32'(busSmall.c_toggle), 32'd1);
            checkOutput($sformatf("sat%0d.big_cnt", k),   32'(busBig.toggle_count), 32'(k + 1));
            checkModel($sformatf("sat%0d", k));
        end

        // Build combo 1111 and count 5 with XOR, then reset mid-run
        applyStimulus(1'b0, 1'b0, 3'b010, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'b010, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b010, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'b010, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b010, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b010, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'b010, 1'b0);
        checkOutput("mid.pre_cnt",   32'(busBig.toggle_count), 32'd5);
        checkOutput("mid.pre_combo", 32'(busBig.combo_seen),   32'hF);
        checkOutput("mid.pre_tog",   32'(busBig.c_toggle),     32'd1);
        applyStimulus(1'b1, 1'b0, 3'b010, 1'b1);
        checkOutput("mid.rst_c",     32'(busBig.c),            32'd0);
        checkOutput("mid.rst_tog",   32'(busBig.c_toggle),     32'd0);
        checkOutput("mid.rst_cnt",   32'(busBig.toggle_count), 32'd0);
        checkOutput("mid.rst_combo", 32'(busBig.combo_seen),   32'd0);
        applyStimulus(1'b1, 1'b0, 3'b010, 1'b0);
        checkOutput("mid.post_c",     32'(busBig.c),            32'd1);
        checkOutput("mid.post_tog",   32'(busBig.c_toggle),     32'd1);
        checkOutput("mid.post_cnt",   32'(busBig.toggle_count), 32'd1);
        checkOutput("mid.post_combo", 32'(busBig.combo_seen),   32'h4);

        // Constant inputs keep everything steady
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 3'b010, 1'b0);
            checkModel($sformatf("hold%0d", k));
            checkOutput($sformatf("hold%0d.tog", k), 32'(busBig.c_toggle), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
